// File: rtl/vga_timing_gen_if.sv
// Raster timing bundle between vga_timing_gen and the sprite/background renderers.
interface vga_timing_gen_if;
    localparam int unsigned COORD_W = 10;
    localparam int unsigned COUNT_W = 8;

    logic               pix_en;
    logic               hs;
    logic               vs;
    logic               blank;
    logic [COORD_W-1:0] DrawX;
    logic [COORD_W-1:0] DrawY;
    logic               line_start;
    logic               frame_start;
    logic [COUNT_W-1:0] frame_count;

    modport master (
        input  pix_en,
        output hs, vs, blank, DrawX, DrawY, line_start, frame_start, frame_count
    );

    modport slave (
        output pix_en,
        input  hs, vs, blank, DrawX, DrawY, line_start, frame_start, frame_count
    );
endinterface

// File: rtl/vga_timing_gen.sv
// 640x480@60 raster timing: pixel coordinates, blanking, syncs and line/frame strobes.
module vga_timing_gen #(
    parameter int unsigned H_VISIBLE   = 640,
    parameter int unsigned H_FRONT     = 16,
    parameter int unsigned H_SYNC      = 96,
    parameter int unsigned H_BACK      = 48,
    parameter int unsigned V_VISIBLE   = 480,
    parameter int unsigned V_FRONT     = 10,
    parameter int unsigned V_SYNC      = 2,
    parameter int unsigned V_BACK      = 33,
    parameter bit          SYNC_ACTIVE = 1'b0
) (
    input  logic             vga_clk,
    input  logic             reset_n,
    vga_timing_gen_if.master vga
);
    localparam int unsigned CW      = 10;
    localparam int unsigned XW      = CW + 1;
    localparam int unsigned FW      = 8;
    localparam int unsigned H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int unsigned V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    // The raster has to fit the 10-bit coordinate counters.
    if (H_TOTAL > 1024 || V_TOTAL > 1024 || H_TOTAL == 0 || V_TOTAL == 0) begin : g_bad_raster
        $error("vga_timing_gen: H_TOTAL and V_TOTAL must be within 1..1024");
    end

    // Compare thresholds carry one extra bit so an end value of 1024 stays representable.
    localparam logic [CW-1:0] H_LAST    = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] V_LAST    = CW'(V_TOTAL - 1);
    localparam logic [XW-1:0] H_VIS_END = XW'(H_VISIBLE);
    localparam logic [XW-1:0] V_VIS_END = XW'(V_VISIBLE);
    localparam logic [XW-1:0] HS_BEG    = XW'(H_VISIBLE + H_FRONT);
    localparam logic [XW-1:0] HS_END    = XW'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [XW-1:0] VS_BEG    = XW'(V_VISIBLE + V_FRONT);
    localparam logic [XW-1:0] VS_END    = XW'(V_VISIBLE + V_FRONT + V_SYNC);

    logic [CW-1:0] hc;
    logic [CW-1:0] vc;
    logic [FW-1:0] fc;
    logic [XW-1:0] hx_c;
    logic [XW-1:0] vx_c;
    logic          h_wrap_c;
    logic          v_wrap_c;
    logic          blank_c;
    logic          hs_c;
    logic          vs_c;
    logic          line_start_c;
    logic          frame_start_c;

    assign hx_c     = {1'b0, hc};
    assign vx_c     = {1'b0, vc};
    assign h_wrap_c = (hc == H_LAST);
    assign v_wrap_c = (vc == V_LAST);

    // Decode the current raster position into the pin values that describe it.
    always_comb begin
        blank_c       = (hx_c < H_VIS_END) && (vx_c < V_VIS_END);
        hs_c          = ((hx_c >= HS_BEG) && (hx_c < HS_END)) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
        vs_c          = ((vx_c >= VS_BEG) && (vx_c < VS_END)) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
        line_start_c  = (hc == '0);
        frame_start_c = (hc == '0) && (vc == '0);
    end

    // Raster counters; frame counter bumps on the full-frame wrap so it lands with frame_start.
    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            hc <= '0;
            vc <= '0;
            fc <= '0;
        end else if (vga.pix_en) begin
            hc <= h_wrap_c ? '0 : hc + CW'(1);
            if (h_wrap_c) begin
                vc <= v_wrap_c ? '0 : vc + CW'(1);
            end
            if (h_wrap_c && v_wrap_c) begin
                fc <= fc + FW'(1);
            end
        end
    end

    // Register the decode so every pin describes the same coordinate, one tick behind the counters.
    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            vga.hs          <= ~SYNC_ACTIVE;
            vga.vs          <= ~SYNC_ACTIVE;
            vga.blank       <= 1'b0;
            vga.DrawX       <= '0;
            vga.DrawY       <= '0;
            vga.line_start  <= 1'b0;
            vga.frame_start <= 1'b0;
            vga.frame_count <= '0;
        end else if (vga.pix_en) begin
            vga.hs          <= hs_c;
            vga.vs          <= vs_c;
            vga.blank       <= blank_c;
            vga.DrawX       <= hc;
            vga.DrawY       <= vc;
            vga.line_start  <= line_start_c;
            vga.frame_start <= frame_start_c;
            vga.frame_count <= fc;
        end
    end
endmodule

// File: tb/tb_vga_timing_gen.sv
// Self-checking bench for vga_timing_gen: a shrunken raster for frame-level behaviour
// plus a default 640x480 instance for the first visible line.
module tb_vga_timing_gen;
    localparam int SH_VIS = 10;
    localparam int SH_FP  = 2;
    localparam int SH_SY  = 3;
    localparam int SH_BP  = 2;
    localparam int SV_VIS = 6;
    localparam int SV_FP  = 2;
    localparam int SV_SY  = 2;
    localparam int SV_BP  = 2;
    localparam int SH_TOT = SH_VIS + SH_FP + SH_SY + SH_BP;
    localparam int SV_TOT = SV_VIS + SV_FP + SV_SY + SV_BP;
    localparam int S_FRAME = SH_TOT * SV_TOT;

    typedef struct packed {
        logic       hs;
        logic       vs;
        logic       blank;
        logic [9:0] x;
        logic [9:0] y;
        logic       ls;
        logic       fs;
        logic [7:0] fc;
    } exp_t;

    logic clk;
    logic reset_n;

    vga_timing_gen_if s_if ();
    vga_timing_gen_if f_if ();

    vga_timing_gen #(
        .H_VISIBLE  (SH_VIS),
        .H_FRONT    (SH_FP),
        .H_SYNC     (SH_SY),
        .H_BACK     (SH_BP),
        .V_VISIBLE  (SV_VIS),
        .V_FRONT    (SV_FP),
        .V_SYNC     (SV_SY),
        .V_BACK     (SV_BP),
        .SYNC_ACTIVE(1'b0)
    ) dut_small (
        .vga_clk(clk),
        .reset_n(reset_n),
        .vga    (s_if)
    );

    vga_timing_gen dut_full (
        .vga_clk(clk),
        .reset_n(reset_n),
        .vga    (f_if)
    );

    int   checks;
    int   errors;
    exp_t sb_q[$];
    int   hc_m;
    int   vc_m;
    int   fc_m;
    exp_t last_m;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic exp_t reset_exp();
        exp_t e;
        e.hs = 1'b1; e.vs = 1'b1; e.blank = 1'b0;
        e.x = '0; e.y = '0; e.ls = 1'b0; e.fs = 1'b0; e.fc = '0;
        return e;
    endfunction

    function automatic exp_t observe();
        exp_t o;
        o.hs = s_if.hs; o.vs = s_if.vs; o.blank = s_if.blank;
        o.x = s_if.DrawX; o.y = s_if.DrawY;
        o.ls = s_if.line_start; o.fs = s_if.frame_start; o.fc = s_if.frame_count;
        return o;
    endfunction

    function automatic string fmt(input exp_t v);
        return $sformatf("x=%0d y=%0d blank=%0b hs=%0b vs=%0b ls=%0b fs=%0b fc=%0d",
                         v.x, v.y, v.blank, v.hs, v.vs, v.ls, v.fs, v.fc);
    endfunction

    task automatic model_reset();
        hc_m = 0; vc_m = 0; fc_m = 0;
        last_m = reset_exp();
        sb_q.delete();
    endtask

    // Reference raster: what the pins show on this enabled tick, then advance.
    task automatic model_tick(output exp_t e);
        e.x     = 10'(hc_m);
        e.y     = 10'(vc_m);
        e.blank = (hc_m < SH_VIS) && (vc_m < SV_VIS);
        e.hs    = !((hc_m >= SH_VIS + SH_FP) && (hc_m < SH_VIS + SH_FP + SH_SY));
        e.vs    = !((vc_m >= SV_VIS + SV_FP) && (vc_m < SV_VIS + SV_FP + SV_SY));
        e.ls    = (hc_m == 0);
        e.fs    = (hc_m == 0) && (vc_m == 0);
        e.fc    = 8'(fc_m);
        if (hc_m == SH_TOT - 1) begin
            hc_m = 0;
            if (vc_m == SV_TOT - 1) begin
                vc_m = 0;
                fc_m = (fc_m + 1) % 256;
            end else begin
                vc_m = vc_m + 1;
            end
        end else begin
            hc_m = hc_m + 1;
        end
    endtask

    // Drive one tick on the small instance and queue the pin values it must produce.
    task automatic drive_tick(input logic en);
        exp_t e;
        s_if.pix_en = en;
        if (en) begin
            model_tick(e);
            last_m = e;
        end else begin
            e = last_m;
        end
        sb_q.push_back(e);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        exp_t o;
        reset_n = 1'b0;
        s_if.pix_en = 1'b1;
        f_if.pix_en = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        o = observe();
        checks++;
        if (o !== reset_exp()) begin
            errors++;
            $display("FAIL reset_small got %s exp %s", fmt(o), fmt(reset_exp()));
        end
        checks++;
        if ({f_if.hs, f_if.vs, f_if.blank, f_if.DrawX, f_if.DrawY, f_if.line_start,
             f_if.frame_start, f_if.frame_count} !== {1'b1, 1'b1, 1'b0, 10'd0, 10'd0, 1'b0, 1'b0, 8'd0}) begin
            errors++;
            $display("FAIL reset_full got x=%0d y=%0d blank=%0b hs=%0b vs=%0b ls=%0b fs=%0b fc=%0d exp reset values",
                     f_if.DrawX, f_if.DrawY, f_if.blank, f_if.hs, f_if.vs, f_if.line_start,
                     f_if.frame_start, f_if.frame_count);
        end
        s_if.pix_en = 1'b0;
        f_if.pix_en = 1'b0;
        reset_n = 1'b1;
        model_reset();
        @(posedge clk);
        @(negedge clk);
        o = observe();
        checks++;
        if (o !== reset_exp()) begin
            errors++;
            $display("FAIL reset_hold_disabled got %s exp %s", fmt(o), fmt(reset_exp()));
        end
    endtask

    task automatic test_full_line();
        int hs_low = 0;
        int hs_min = 1023;
        int hs_max = 0;
        int ls_cnt = 0;
        int bad_x = 0;
        int bad_blank = 0;
        for (int i = 0; i < 800; i++) begin
            f_if.pix_en = 1'b1;
            @(posedge clk);
            @(negedge clk);
            if (i == 0) begin
                checks++;
                if ({f_if.DrawX, f_if.DrawY, f_if.blank, f_if.frame_start, f_if.hs, f_if.vs} !==
                    {10'd0, 10'd0, 1'b1, 1'b1, 1'b1, 1'b1}) begin
                    errors++;
                    $display("FAIL full_first_tick got x=%0d y=%0d blank=%0b fs=%0b hs=%0b vs=%0b exp 0 0 1 1 1 1",
                             f_if.DrawX, f_if.DrawY, f_if.blank, f_if.frame_start, f_if.hs, f_if.vs);
                end
            end
            if (i == 640) begin
                checks++;
                if ({f_if.DrawX, f_if.blank} !== {10'd640, 1'b0}) begin
                    errors++;
                    $display("FAIL full_tick640 got x=%0d blank=%0b exp x=640 blank=0", f_if.DrawX, f_if.blank);
                end
            end
            if (f_if.DrawX !== 10'(i)) bad_x++;
            if (f_if.blank !== (i < 640)) bad_blank++;
            if (f_if.hs === 1'b0) begin
                hs_low++;
                if (int'(f_if.DrawX) < hs_min) hs_min = int'(f_if.DrawX);
                if (int'(f_if.DrawX) > hs_max) hs_max = int'(f_if.DrawX);
            end
            if (f_if.line_start === 1'b1) ls_cnt++;
        end
        f_if.pix_en = 1'b0;
        checks++;
        if (hs_low != 96) begin errors++; $display("FAIL full_hs_width got %0d exp 96", hs_low); end
        checks++;
        if (hs_min != 656 || hs_max != 751) begin
            errors++;
            $display("FAIL full_hs_span got %0d..%0d exp 656..751", hs_min, hs_max);
        end
        checks++;
        if (ls_cnt != 1) begin errors++; $display("FAIL full_line_start got %0d exp 1", ls_cnt); end
        checks++;
        if (bad_x != 0) begin errors++; $display("FAIL full_drawx_seq got %0d bad exp 0", bad_x); end
        checks++;
        if (bad_blank != 0) begin errors++; $display("FAIL full_blank got %0d bad exp 0", bad_blank); end
    endtask

    task automatic test_first_tick();
        exp_t e;
        exp_t o;
        drive_tick(1'b1);
        e = sb_q.pop_front();
        o = observe();
        checks++;
        if (o !== e) begin errors++; $display("FAIL first_tick_sb got %s exp %s", fmt(o), fmt(e)); end
        checks++;
        if ({o.x, o.y, o.blank, o.ls, o.fs, o.hs, o.vs, o.fc} !==
            {10'd0, 10'd0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 8'd0}) begin
            errors++;
            $display("FAIL first_tick got %s exp x=0 y=0 blank=1 hs=1 vs=1 ls=1 fs=1 fc=0", fmt(o));
        end
    endtask

    task automatic test_hsync();
        exp_t e;
        exp_t o;
        int hs_low = 0;
        int hs_min = 1023;
        int hs_max = 0;
        int ls_cnt = 0;
        for (int i = 0; i < SH_TOT; i++) begin
            drive_tick(1'b1);
            e = sb_q.pop_front();
            o = observe();
            checks++;
            if (o !== e) begin errors++; $display("FAIL hsync_sb got %s exp %s", fmt(o), fmt(e)); end
            if (o.hs === 1'b0) begin
                hs_low++;
                if (int'(o.x) < hs_min) hs_min = int'(o.x);
                if (int'(o.x) > hs_max) hs_max = int'(o.x);
            end
            if (o.ls === 1'b1) ls_cnt++;
        end
        checks++;
        if (hs_low != SH_SY) begin errors++; $display("FAIL hsync_width got %0d exp %0d", hs_low, SH_SY); end
        checks++;
        if (hs_min != SH_VIS + SH_FP || hs_max != SH_VIS + SH_FP + SH_SY - 1) begin
            errors++;
            $display("FAIL hsync_span got %0d..%0d exp %0d..%0d", hs_min, hs_max,
                     SH_VIS + SH_FP, SH_VIS + SH_FP + SH_SY - 1);
        end
        checks++;
        if (ls_cnt != 1) begin errors++; $display("FAIL hsync_line_start got %0d exp 1", ls_cnt); end
    endtask

    task automatic test_vsync();
        exp_t e;
        exp_t o;
        logic prev_vs = 1'b1;
        int vs_low = 0;
        int vs_min = 1023;
        int vs_max = 0;
        int bad_blank = 0;
        int vs_mid_line = 0;
        int fs_cnt = 0;
        for (int i = 0; i < S_FRAME; i++) begin
            drive_tick(1'b1);
            e = sb_q.pop_front();
            o = observe();
            checks++;
            if (o !== e) begin errors++; $display("FAIL vsync_sb got %s exp %s", fmt(o), fmt(e)); end
            if (o.vs === 1'b0) begin
                vs_low++;
                if (int'(o.y) < vs_min) vs_min = int'(o.y);
                if (int'(o.y) > vs_max) vs_max = int'(o.y);
            end
            if (i > 0 && o.vs !== prev_vs && o.x !== 10'd0) vs_mid_line++;
            prev_vs = o.vs;
            if (o.blank === 1'b1 && int'(o.y) >= SV_VIS) bad_blank++;
            if (o.fs === 1'b1) fs_cnt++;
        end
        checks++;
        if (vs_low != SV_SY * SH_TOT) begin
            errors++;
            $display("FAIL vsync_width got %0d exp %0d", vs_low, SV_SY * SH_TOT);
        end
        checks++;
        if (vs_min != SV_VIS + SV_FP || vs_max != SV_VIS + SV_FP + SV_SY - 1) begin
            errors++;
            $display("FAIL vsync_lines got %0d..%0d exp %0d..%0d", vs_min, vs_max,
                     SV_VIS + SV_FP, SV_VIS + SV_FP + SV_SY - 1);
        end
        checks++;
        if (vs_mid_line != 0) begin errors++; $display("FAIL vsync_mid_line got %0d exp 0", vs_mid_line); end
        checks++;
        if (bad_blank != 0) begin errors++; $display("FAIL blank_below_visible got %0d exp 0", bad_blank); end
        checks++;
        if (fs_cnt != 1) begin errors++; $display("FAIL frame_start_count got %0d exp 1", fs_cnt); end
    endtask

    task automatic test_pix_en_toggle();
        exp_t e;
        exp_t o;
        int px;
        int guard;
        logic en;
        px = int'(last_m.x);
        for (int i = 0; i < 40; i++) begin
            en = (i % 2 == 0);
            drive_tick(en);
            if (en) px = (px + 1) % SH_TOT;
            e = sb_q.pop_front();
            o = observe();
            checks++;
            if (o !== e) begin errors++; $display("FAIL toggle_sb got %s exp %s", fmt(o), fmt(e)); end
            checks++;
            if (int'(o.x) != px) begin errors++; $display("FAIL toggle_step got x=%0d exp %0d", o.x, px); end
        end
        // Run up to the next frame start, then stall with the strobe pending.
        guard = 0;
        while (!(hc_m == 0 && vc_m == 0) && guard <= S_FRAME) begin
            drive_tick(1'b1);
            e = sb_q.pop_front();
            o = observe();
            checks++;
            if (o !== e) begin errors++; $display("FAIL toggle_seek_sb got %s exp %s", fmt(o), fmt(e)); end
            guard++;
        end
        drive_tick(1'b1);
        e = sb_q.pop_front();
        o = observe();
        checks++;
        if ({o.x, o.y, o.fs, o.ls} !== {10'd0, 10'd0, 1'b1, 1'b1}) begin
            errors++;
            $display("FAIL toggle_fs_arrive got %s exp x=0 y=0 fs=1 ls=1", fmt(o));
        end
        for (int i = 0; i < 4; i++) begin
            drive_tick(1'b0);
            e = sb_q.pop_front();
            o = observe();
            checks++;
            if ({o.x, o.y, o.fs, o.ls, o.blank} !== {10'd0, 10'd0, 1'b1, 1'b1, 1'b1}) begin
                errors++;
                $display("FAIL toggle_fs_hold got %s exp x=0 y=0 fs=1 ls=1 blank=1", fmt(o));
            end
        end
        drive_tick(1'b1);
        e = sb_q.pop_front();
        o = observe();
        checks++;
        if ({o.x, o.fs, o.ls} !== {10'd1, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL toggle_fs_release got %s exp x=1 fs=0 ls=0", fmt(o));
        end
    endtask

    task automatic test_reset_mid_frame();
        exp_t e;
        exp_t o;
        int guard = 0;
        logic found = 1'b0;
        while (!found && guard <= S_FRAME) begin
            drive_tick(1'b1);
            e = sb_q.pop_front();
            o = observe();
            checks++;
            if (o !== e) begin errors++; $display("FAIL midreset_seek_sb got %s exp %s", fmt(o), fmt(e)); end
            if (e.x == 10'd5 && e.y == 10'd3) found = 1'b1;
            guard++;
        end
        checks++;
        if (!found || o.fc === 8'd0) begin
            errors++;
            $display("FAIL midreset_setup got %s exp x=5 y=3 fc>0", fmt(o));
        end
        s_if.pix_en = 1'b1;
        @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        o = observe();
        checks++;
        if (o !== reset_exp()) begin
            errors++;
            $display("FAIL midreset_async got %s exp %s", fmt(o), fmt(reset_exp()));
        end
        @(negedge clk);
        s_if.pix_en = 1'b0;
        reset_n = 1'b1;
        model_reset();
        @(posedge clk);
        @(negedge clk);
        drive_tick(1'b1);
        e = sb_q.pop_front();
        o = observe();
        checks++;
        if ({o.x, o.y, o.fs, o.ls, o.blank, o.fc} !== {10'd0, 10'd0, 1'b1, 1'b1, 1'b1, 8'd0}) begin
            errors++;
            $display("FAIL midreset_restart got %s exp x=0 y=0 fs=1 ls=1 blank=1 fc=0", fmt(o));
        end
    endtask

    // Starts right after a reset release and one enabled tick, so tick t is frame t/S_FRAME.
    task automatic test_frame_count();
        exp_t e;
        exp_t o;
        int n;
        for (int t = 1; t <= 257 * S_FRAME; t++) begin
            drive_tick(1'b1);
            e = sb_q.pop_front();
            o = observe();
            checks++;
            if (o !== e) begin errors++; $display("FAIL frame_count_sb got %s exp %s", fmt(o), fmt(e)); end
            if (t % S_FRAME == 0) begin
                n = t / S_FRAME;
                checks++;
                if ({o.fs, o.fc} !== {1'b1, 8'(n % 256)}) begin
                    errors++;
                    $display("FAIL frame_count_wrap%0d got fs=%0b fc=%0d exp fs=1 fc=%0d", n, o.fs, o.fc, n % 256);
                end
                if (n == 255 || n == 256 || n == 257) begin
                    checks++;
                    if (o.fc !== ((n == 255) ? 8'd255 : (n == 256) ? 8'd0 : 8'd1)) begin
                        errors++;
                        $display("FAIL frame_count_boundary%0d got %0d", n, o.fc);
                    end
                end
            end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset_n = 1'b0;
        s_if.pix_en = 1'b0;
        f_if.pix_en = 1'b0;
        model_reset();
        @(negedge clk);
        test_reset();
        test_full_line();
        test_first_tick();
        test_hsync();
        test_vsync();
        test_pix_en_toggle();
        test_reset_mid_frame();
        test_frame_count();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Generates the 640x480@60 Hz raster timing that drives every sprite and background renderer in the display path. Produces the pixel coordinates (DrawX, DrawY), the active-video flag (blank, high = visible), the horizontal and vertical sync pulses, and per-line/per-frame strobes. Sprite blocks consume DrawX, DrawY and blank to form ROM addresses and gate palette output. Sprite animation logic consumes frame_start and frame_count.

## Interface
Parameters:
- H_VISIBLE, 640, active pixels per line
- H_FRONT, 16, horizontal front porch (pixels)
- H_SYNC, 96, horizontal sync width (pixels)
- H_BACK, 48, horizontal back porch (pixels)
- V_VISIBLE, 480, active lines per frame
- V_FRONT, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BACK, 33, vertical back porch (lines)
- SYNC_ACTIVE, 0, level of hs/vs during the sync pulse

Ports:
- vga_clk  input  1  pixel-domain clock; all state on its rising edge
- reset_n  input  1  asynchronous, active-low reset
- pix_en  input  1  pixel tick; state advances only on edges where pix_en=1
- hs  output  1  horizontal sync
- vs  output  1  vertical sync
- blank  output  1  1 = visible pixel, 0 = blanking interval
- DrawX  output  10  horizontal coordinate, 0..H_TOTAL-1
- DrawY  output  10  vertical coordinate, 0..V_TOTAL-1
- line_start  output  1  one-tick strobe at DrawX=0
- frame_start  output  1  one-tick strobe at DrawX=0, DrawY=0
- frame_count  output  8  completed-frame counter

## Operation
- H_TOTAL = sum of the H_* parameters (800). V_TOTAL = sum of the V_* parameters (525). Both must be ≤1024; a static assertion enforces this.
- Internal counters hc and vc are 10 bits wide.
- hc increments each tick and wraps H_TOTAL-1 → 0.
- vc increments on hc wrap and wraps V_TOTAL-1 → 0 on the same tick that hc wraps.
- Outputs are registered decodes of (hc, vc), loaded on the same enabled tick that the counters advance. DrawX/DrawY always equal the coordinate the other outputs describe.
- blank = (hc < H_VISIBLE) && (vc < V_VISIBLE).
- hs = SYNC_ACTIVE when H_VISIBLE+H_FRONT ≤ hc < H_VISIBLE+H_FRONT+H_SYNC, i.e. DrawX 656..751. Otherwise hs = ~SYNC_ACTIVE.
- vs = SYNC_ACTIVE when V_VISIBLE+V_FRONT ≤ vc < V_VISIBLE+V_FRONT+V_SYNC, i.e. DrawY 490..491. vs is line-based: it changes only at DrawX=0.
- line_start = (hc==0). frame_start = (hc==0 && vc==0).
- frame_count increments on the tick where the counters wrap (H_TOTAL-1, V_TOTAL-1) → (0,0). It wraps 255 → 0. The first frame after reset does not increment it.
- pix_en=0: counters and all outputs hold, including the strobes (a strobe stays high until the next enabled tick).

## Timing
- Reset (asynchronous, while reset_n=0):
  - hc = vc = 0, frame_count = 0, DrawX = DrawY = 0
  - blank = 0, line_start = 0, frame_start = 0
  - hs = vs = ~SYNC_ACTIVE
- First enabled tick after reset release: outputs show coordinate (0,0) with blank=1, line_start=1, frame_start=1. Counters move to (1,0).
- Output latency: one enabled tick from counter state to pins. There is no combinational path from the inputs to any output.
- Line period is H_TOTAL enabled ticks; frame period is H_TOTAL*V_TOTAL = 420000 enabled ticks.
- Reset asserted mid-frame: all state clears immediately, without waiting for a clock edge. Raster restarts at (0,0) on the first enabled tick after release.
- Simultaneous hc wrap and vc wrap: frame_start, line_start and the frame_count increment all take effect on the same tick.

## Test plan
- Reset then pix_en=1 constant:
  - first tick → DrawX=0, DrawY=0, blank=1, frame_start=1, hs=vs=1
  - tick 640 → DrawX=640, blank=0
- Horizontal sync: over one line, hs is low for exactly 96 consecutive ticks, with DrawX from 656 to 751; line_start pulses once per 800 ticks.
- Vertical sync: over one frame, vs is low exactly for lines DrawY=490 and 491. No blank=1 ever occurs with DrawY ≥ 480. frame_start pulses once per 420000 ticks.
- frame_count: run 257 frame wraps → frame_count reads 255 after 255 wraps, then 0, then 1.
- pix_en toggling 1,0,1,0: DrawX advances by exactly one per enabled tick. Outputs, including a pending frame_start, hold while pix_en=0.
- Assert reset_n=0 at DrawX=300, DrawY=200, asynchronous to vga_clk:
  - outputs go to reset values within the same cycle
  - on release, the raster resumes at (0,0) with frame_count=0
